sram_port_arbiter: RTL and testbench

Two-requester arbiter and access sequencer in front of the shared 32-bit sram model. Port 0 is instruction fetch and port 1 is the data load/store unit. The block accepts one request at a time using round-robin priority. It then drives sram cs/oe/we/addr/din stable for a fixed number of cycles, samples dout, and returns a one-cycle response to the winning port. It deasserts cs between transactions so the level/event-driven sram sees a fresh access every time.

---
 rtl/sram_ctrl_pkg.sv | 16 +
 rtl/sram_port_arbiter_if.sv | 25 ++
 rtl/sram_port_arbiter_rr_arb2.sv | 30 +++
 rtl/sram_port_arbiter.sv | 123 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the sram access sequencer and its requesters.
package sram_ctrl_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_DATA   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side request/response bundle for one sram arbiter port.
interface sram_port_arbiter_if
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req_valid, we, addr, wdata,
        input  req_ready, rvalid, rdata
    );

    modport slave (
        input  req_valid, we, addr, wdata,
        output req_ready, rvalid, rdata
    );
endinterface

// File: rtl/sram_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: one-hot grant plus the pointer to use next time.
module rr_arb2
    import sram_ctrl_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       ptr_next
);

    // Pointer only breaks ties; a lone requester always wins.
    always_comb begin
        gnt      = 2'b00;
        ptr_next = ptr;
        if (en) begin
            if (&valid) begin
                gnt = (ptr == PORT_DATA) ? 2'b10 : 2'b01;
            end else begin
                gnt = valid;
            end
        end
        if (gnt[0]) begin
            ptr_next = PORT_DATA;
        end else if (gnt[1]) begin
            ptr_next = PORT_IFETCH;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one sram and sequences
// each access as a fixed-length cs pulse followed by a one-cycle response.
module sram_port_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    sram_port_arbiter_if.slave  p0,
    sram_port_arbiter_if.slave  p1,
    output logic                mem_cs,
    output logic                mem_oe,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_din,
    input  logic [DATA_W-1:0]   mem_dout,
    output logic                busy
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    generate
        if (ACCESS_CYCLES < 1) begin : g_bad_access_cycles
            $error("sram_port_arbiter: ACCESS_CYCLES must be >= 1");
        end
    endgenerate

    state_t            state;
    logic              ptr;
    logic [CNT_W-1:0]  cnt;
    logic              lat_we;
    logic              gnt_id;
    logic [1:0]        gnt;
    logic              ptr_next;
    logic              arb_en;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Gating with rst_n keeps ready low while the block is held in reset.
    assign arb_en = rst_n && (state == IDLE);

    rr_arb2 u_rr_arb2 (
        .valid    ({p1.req_valid, p0.req_valid}),
        .ptr      (ptr),
        .en       (arb_en),
        .gnt      (gnt),
        .ptr_next (ptr_next)
    );

    assign p0.req_ready = gnt[0];
    assign p1.req_ready = gnt[1];
    assign busy         = (state != IDLE);

    assign sel_we    = gnt[1] ? p1.we    : p0.we;
    assign sel_addr  = gnt[1] ? p1.addr  : p0.addr;
    assign sel_wdata = gnt[1] ? p1.wdata : p0.wdata;

    // Access sequencer: accept, hold the sram pins for ACCESS_CYCLES, respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= PORT_IFETCH;
            cnt       <= '0;
            lat_we    <= 1'b0;
            gnt_id    <= PORT_IFETCH;
            mem_cs    <= 1'b0;
            mem_oe    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            p0.rvalid <= 1'b0;
            p0.rdata  <= '0;
            p1.rvalid <= 1'b0;
            p1.rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        gnt_id   <= gnt[1];
                        ptr      <= ptr_next;
                        cnt      <= CNT_LOAD;
                        lat_we   <= sel_we;
                        mem_cs   <= 1'b1;
                        mem_we   <= sel_we;
                        mem_oe   <= ~sel_we;
                        mem_addr <= sel_addr;
                        mem_din  <= sel_we ? sel_wdata : '0;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        mem_cs <= 1'b0;
                        mem_oe <= 1'b0;
                        mem_we <= 1'b0;
                        if (gnt_id == PORT_DATA) begin
                            p1.rvalid <= 1'b1;
                            if (!lat_we) p1.rdata <= mem_dout;
                        end else begin
                            p0.rvalid <= 1'b1;
                            if (!lat_we) p0.rdata <= mem_dout;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    p0.rvalid <= 1'b0;
                    p1.rvalid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small behavioural sram.
module tb_sram_port_arbiter;
    import sram_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        mem_cs, mem_oe, mem_we, busy;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic [31:0] mem [0:255];

    int total  = 0;
    int passed = 0;

    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p0_bus ();
    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p1_bus ();

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .ACCESS_CYCLES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .p0       (p0_bus),
        .p1       (p1_bus),
        .mem_cs   (mem_cs),
        .mem_oe   (mem_oe),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_cs && mem_we) mem[mem_addr[9:2]] <= mem_din;
    end
    assign mem_dout = (mem_cs && mem_oe) ? mem[mem_addr[9:2]] : 32'h0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        p0_bus.req_valid = 1'b1; p0_bus.we = 1'b1; p0_bus.addr = 32'h10; p0_bus.wdata = 32'hDEADBEEF;
        p1_bus.req_valid = 1'b1; p1_bus.we = 1'b0; p1_bus.addr = 32'h10; p1_bus.wdata = 32'h0;

        // Reset held with both requests pending
        repeat (3) tick();
        check("rst_ready0", p0_bus.req_ready, 0);
        check("rst_ready1", p1_bus.req_ready, 0);
        check("rst_cs", mem_cs, 0);
        check("rst_oe", mem_oe, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_din", mem_din, 0);
        check("rst_rvalid0", p0_bus.rvalid, 0);
        check("rst_rvalid1", p1_bus.rvalid, 0);
        check("rst_rdata0", p0_bus.rdata, 0);
        check("rst_rdata1", p1_bus.rdata, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        #1;
        check("rel_ready0", p0_bus.req_ready, 1);
        check("rel_ready1", p1_bus.req_ready, 0);

        // p0 write 0x10 <- DEADBEEF
        tick(); p0_bus.req_valid = 1'b0;
        check("wr_c1_cs", mem_cs, 1);
        check("wr_c1_we", mem_we, 1);
        check("wr_c1_oe", mem_oe, 0);
        check("wr_c1_addr", mem_addr, 32'h10);
        check("wr_c1_din", mem_din, 32'hDEADBEEF);
        check("wr_c1_busy", busy, 1);
        check("wr_c1_ready1", p1_bus.req_ready, 0);
        tick();
        check("wr_c2_cs", mem_cs, 1);
        check("wr_c2_we", mem_we, 1);
        check("wr_c2_addr", mem_addr, 32'h10);
        check("wr_c2_din", mem_din, 32'hDEADBEEF);
        check("wr_c2_rvalid0", p0_bus.rvalid, 0);
        tick();
        check("wr_c3_rvalid0", p0_bus.rvalid, 1);
        check("wr_c3_rvalid1", p1_bus.rvalid, 0);
        check("wr_c3_cs", mem_cs, 0);
        check("wr_c3_we", mem_we, 0);
        check("wr_c3_rdata0", p0_bus.rdata, 0);
        check("wr_c3_addr_hold", mem_addr, 32'h10);
        check("wr_c3_din_hold", mem_din, 32'hDEADBEEF);
        tick();
        check("wr_c4_rvalid0", p0_bus.rvalid, 0);
        check("wr_c4_busy", busy, 0);
        check("rd_c4_ready1", p1_bus.req_ready, 1);
        check("rd_c4_ready0", p0_bus.req_ready, 0);

        // p1 read 0x10
        tick(); p1_bus.req_valid = 1'b0;
        check("rd_c5_cs", mem_cs, 1);
        check("rd_c5_oe", mem_oe, 1);
        check("rd_c5_we", mem_we, 0);
        check("rd_c5_addr", mem_addr, 32'h10);
        check("rd_c5_din", mem_din, 0);
        tick();
        check("rd_c6_cs", mem_cs, 1);
        check("rd_c6_oe", mem_oe, 1);
        check("rd_c6_rvalid1", p1_bus.rvalid, 0);
        tick();
        check("rd_c7_rvalid1", p1_bus.rvalid, 1);
        check("rd_c7_rdata1", p1_bus.rdata, 32'hDEADBEEF);
        check("rd_c7_oe", mem_oe, 0);
        check("rd_c7_rvalid0", p0_bus.rvalid, 0);
        tick();
        check("rd_c8_rvalid1", p1_bus.rvalid, 0);
        check("rd_c8_rdata1_hold", p1_bus.rdata, 32'hDEADBEEF);
        check("rd_c8_rdata0", p0_bus.rdata, 0);

        // Both ports requesting continuously: alternate grants every 4 cycles
        rst_n = 1'b0;
        p0_bus.req_valid = 1'b1; p0_bus.we = 1'b0; p0_bus.addr = 32'h10;
        p1_bus.req_valid = 1'b1; p1_bus.we = 1'b0; p1_bus.addr = 32'h20;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 16; c++) begin
            check($sformatf("rr_c%0d_ready0", c), p0_bus.req_ready, (c % 8 == 0) ? 1 : 0);
            check($sformatf("rr_c%0d_ready1", c), p1_bus.req_ready, (c % 8 == 4) ? 1 : 0);
            check($sformatf("rr_c%0d_both", c), p0_bus.req_ready & p1_bus.req_ready, 0);
            check($sformatf("rr_c%0d_rvalid0", c), p0_bus.rvalid, (c % 8 == 3) ? 1 : 0);
            check($sformatf("rr_c%0d_rvalid1", c), p1_bus.rvalid, (c % 8 == 7) ? 1 : 0);
            if (c == 3) check("rr_c3_rdata0", p0_bus.rdata, 32'hDEADBEEF);
            tick();
        end
        p0_bus.req_valid = 1'b0;
        p1_bus.req_valid = 1'b0;

        // Reset during the first ACCESS cycle of a p1 write
        rst_n = 1'b0;
        p1_bus.req_valid = 1'b1; p1_bus.we = 1'b1; p1_bus.addr = 32'h30; p1_bus.wdata = 32'h12345678;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("ab_ready1", p1_bus.req_ready, 1);
        check("ab_ready0", p0_bus.req_ready, 0);
        tick();
        check("ab_c1_cs", mem_cs, 1);
        check("ab_c1_we", mem_we, 1);
        #3 rst_n = 1'b0;
        #1;
        check("ab_async_cs", mem_cs, 0);
        check("ab_async_we", mem_we, 0);
        check("ab_async_busy", busy, 0);
        check("ab_async_addr", mem_addr, 0);
        p0_bus.req_valid = 1'b1; p0_bus.we = 1'b0; p0_bus.addr = 32'h10;
        tick();
        check("ab_r1_rvalid1", p1_bus.rvalid, 0);
        tick();
        check("ab_r2_rvalid1", p1_bus.rvalid, 0);
        rst_n = 1'b1;
        #1;
        check("ab_rel_ready0", p0_bus.req_ready, 1);
        check("ab_rel_ready1", p1_bus.req_ready, 0);
        tick(); p0_bus.req_valid = 1'b0; p1_bus.req_valid = 1'b0;
        check("ab_c1_rvalid1", p1_bus.rvalid, 0);
        tick();
        tick();
        check("ab_c3_rvalid0", p0_bus.rvalid, 1);
        check("ab_c3_rvalid1", p1_bus.rvalid, 0);

        // p0: write 0x20, then two back-to-back reads of 0x20
        rst_n = 1'b0;
        repeat (2) tick();
        p0_bus.req_valid = 1'b1; p0_bus.we = 1'b1; p0_bus.addr = 32'h20; p0_bus.wdata = 32'hCAFEF00D;
        rst_n = 1'b1;
        #1;
        check("bb_c0_ready0", p0_bus.req_ready, 1);
        tick(); p0_bus.we = 1'b0; p0_bus.wdata = 32'h0;
        tick();
        tick();
        tick();
        check("bb_c4_ready0", p0_bus.req_ready, 1);
        check("bb_c4_cs", mem_cs, 0);
        tick();
        check("bb_c5_cs", mem_cs, 1);
        check("bb_c5_oe", mem_oe, 1);
        tick();
        check("bb_c6_cs", mem_cs, 1);
        tick();
        check("bb_c7_cs", mem_cs, 0);
        check("bb_c7_rvalid0", p0_bus.rvalid, 1);
        check("bb_c7_rdata0", p0_bus.rdata, 32'hCAFEF00D);
        tick();
        check("bb_c8_cs", mem_cs, 0);
        check("bb_c8_ready0", p0_bus.req_ready, 1);
        check("bb_c8_rvalid0", p0_bus.rvalid, 0);
        tick(); p0_bus.req_valid = 1'b0;
        check("bb_c9_cs", mem_cs, 1);
        check("bb_c9_oe", mem_oe, 1);
        check("bb_c9_addr", mem_addr, 32'h20);
        tick();
        check("bb_c10_cs", mem_cs, 1);
        tick();
        check("bb_c11_cs", mem_cs, 0);
        check("bb_c11_rvalid0", p0_bus.rvalid, 1);
        check("bb_c11_rdata0", p0_bus.rdata, 32'hCAFEF00D);
        tick();
        check("bb_c12_rvalid0", p0_bus.rvalid, 0);
        check("bb_c12_busy", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
